ks_note_sequencer: RTL and testbench

Step sequencer that plays a programmed note pattern on the Karplus-Strong string voice. It holds a small per-step pattern memory written through the SPI register-map write port. On `start_i` it walks the steps, presenting period and dynamics values and a pluck pulse to `ks_string` for each step, and holds each step for a programmed duration measured in sample ticks. It sits between `register_map` and `ks_string`, replacing direct register-driven pluck, period and dynamics control.

---
 rtl/ks_note_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_ks_note_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_note_sequencer.sv
// ks_note_sequencer: step sequencer driving the Karplus-Strong string voice.
// Holds a per-step {period, dynamics, duration} pattern memory written from
// the register map and, once started, plays each step for duration x (tempo+1)
// sample ticks. Every step begins with a registered pluck pulse.
module ks_note_sequencer #(
   parameter int unsigned NUM_STEPS   = 16,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned TEMPO_WIDTH = 16,
   parameter int unsigned PLUCK_LEN   = 4,
   localparam int unsigned SW         = $clog2(NUM_STEPS)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   tick_i,
   input  logic                   wr_en_i,
   input  logic [SW+1:0]          wr_addr_i,
   input  logic [DATA_WIDTH-1:0]  wr_data_i,
   input  logic                   start_i,
   input  logic                   stop_i,
   input  logic                   loop_en_i,
   input  logic [SW:0]            length_i,
   input  logic [TEMPO_WIDTH-1:0] tempo_i,
   output logic [DATA_WIDTH-1:0]  period_o,
   output logic [DATA_WIDTH-1:0]  dynamics_R_o,
   output logic                   pluck_o,
   output logic                   busy_o,
   output logic [SW-1:0]          step_o,
   output logic                   done_o
);

   localparam int unsigned PW = $clog2(PLUCK_LEN + 1);
   localparam logic [PW-1:0] PLUCK_END  = PW'(PLUCK_LEN);
   localparam logic [PW-1:0] PLUCK_LAST = PW'(PLUCK_LEN - 1);
   localparam logic [DATA_WIDTH:0] DUR_FULL = {1'b1, {DATA_WIDTH{1'b0}}};
   localparam logic [DATA_WIDTH:0] DUR_ONE  = (DATA_WIDTH + 1)'(1);
   localparam logic [SW:0] LEN_MAX = (SW + 1)'(NUM_STEPS);
   localparam logic [SW:0] STEP_INC = (SW + 1)'(1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_PLAY
   } state_t;

   state_t                 state_q, state_d;
   logic [SW-1:0]          step_q, step_d;
   logic [SW:0]            len_q, len_d;
   logic [TEMPO_WIDTH-1:0] tempo_q, tempo_d;
   logic [DATA_WIDTH:0]    dur_cnt_q, dur_cnt_d;
   logic [TEMPO_WIDTH-1:0] unit_cnt_q, unit_cnt_d;
   logic [PW-1:0]          pluck_cnt_q, pluck_cnt_d;
   logic [DATA_WIDTH-1:0]  period_q, period_d;
   logic [DATA_WIDTH-1:0]  dyn_q, dyn_d;
   logic                   pluck_q, pluck_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   logic [DATA_WIDTH-1:0]  mem_period [NUM_STEPS];
   logic [DATA_WIDTH-1:0]  mem_dyn    [NUM_STEPS];
   logic [DATA_WIDTH-1:0]  mem_dur    [NUM_STEPS];

   logic [SW-1:0]          wr_step;
   logic [1:0]             wr_field;
   logic [DATA_WIDTH-1:0]  rd_period, rd_dyn, rd_dur;
   logic [SW:0]            step_next;

   assign wr_step   = wr_addr_i[SW+1:2];
   assign wr_field  = wr_addr_i[1:0];
   assign rd_period = mem_period[step_q];
   assign rd_dyn    = mem_dyn[step_q];
   assign rd_dur    = mem_dur[step_q];
   assign step_next = {1'b0, step_q} + STEP_INC;

   // Pattern memory: unreset, writable in any state, field 3 dropped.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         case (wr_field)
            2'd0:    mem_period[wr_step] <= wr_data_i;
            2'd1:    mem_dyn[wr_step]    <= wr_data_i;
            2'd2:    mem_dur[wr_step]    <= wr_data_i;
            default: ;
         endcase
      end
   end

   // Next-state and next-output logic; stop overrides everything else.
   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      len_d       = len_q;
      tempo_d     = tempo_q;
      dur_cnt_d   = dur_cnt_q;
      unit_cnt_d  = unit_cnt_q;
      pluck_cnt_d = pluck_cnt_q;
      period_d    = period_q;
      dyn_d       = dyn_q;
      pluck_d     = pluck_q;
      done_d      = 1'b0;

      if (stop_i) begin
         state_d = ST_IDLE;
         pluck_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i && (length_i != '0)) begin
                  state_d = ST_LOAD;
                  step_d  = '0;
                  len_d   = (length_i > LEN_MAX) ? LEN_MAX : length_i;
                  tempo_d = tempo_i;
               end
            end
            ST_LOAD: begin
               state_d     = ST_PLAY;
               period_d    = rd_period;
               dyn_d       = rd_dyn;
               pluck_d     = 1'b1;
               dur_cnt_d   = (rd_dur == '0) ? DUR_FULL : {1'b0, rd_dur};
               unit_cnt_d  = '0;
               pluck_cnt_d = '0;
            end
            ST_PLAY: begin
               if (tick_i) begin
                  if (pluck_cnt_q != PLUCK_END) begin
                     pluck_cnt_d = pluck_cnt_q + 1'b1;
                     if (pluck_cnt_q == PLUCK_LAST) begin
                        pluck_d = 1'b0;
                     end
                  end
                  if (unit_cnt_q == tempo_q) begin
                     unit_cnt_d = '0;
                     dur_cnt_d  = dur_cnt_q - 1'b1;
                     if (dur_cnt_q == DUR_ONE) begin
                        // Step ends on this tick; a still-running pluck is cut short.
                        pluck_d = 1'b0;
                        if (step_next < len_q) begin
                           step_d  = step_next[SW-1:0];
                           state_d = ST_LOAD;
                        end else if (loop_en_i) begin
                           step_d  = '0;
                           state_d = ST_LOAD;
                        end else begin
                           state_d = ST_IDLE;
                           done_d  = 1'b1;
                        end
                     end
                  end else begin
                     unit_cnt_d = unit_cnt_q + 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         step_q      <= '0;
         len_q       <= '0;
         tempo_q     <= '0;
         dur_cnt_q   <= '0;
         unit_cnt_q  <= '0;
         pluck_cnt_q <= '0;
         period_q    <= '0;
         dyn_q       <= '0;
         pluck_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         len_q       <= len_d;
         tempo_q     <= tempo_d;
         dur_cnt_q   <= dur_cnt_d;
         unit_cnt_q  <= unit_cnt_d;
         pluck_cnt_q <= pluck_cnt_d;
         period_q    <= period_d;
         dyn_q       <= dyn_d;
         pluck_q     <= pluck_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign period_o     = period_q;
   assign dynamics_R_o = dyn_q;
   assign pluck_o      = pluck_q;
   assign busy_o       = busy_q;
   assign step_o       = step_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Bench for ks_note_sequencer: table-driven single pass, directed corner
// sequences and a randomized run against a step/tick-count reference model.
module tb_ks_note_sequencer;

   localparam int unsigned NS = 16;
   localparam int unsigned DW = 8;
   localparam int unsigned TW = 16;
   localparam int unsigned PL = 4;
   localparam int unsigned SW = 4;

   logic          clk = 1'b0;
   logic          rst_i, tick_i, wr_en_i, start_i, stop_i, loop_en_i;
   logic [SW+1:0] wr_addr_i;
   logic [DW-1:0] wr_data_i;
   logic [SW:0]   length_i;
   logic [TW-1:0] tempo_i;
   logic [DW-1:0] period_o, dynamics_R_o;
   logic          pluck_o, busy_o, done_o;
   logic [SW-1:0] step_o;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   ks_note_sequencer #(
      .NUM_STEPS  (NS),
      .DATA_WIDTH (DW),
      .TEMPO_WIDTH(TW),
      .PLUCK_LEN  (PL)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .tick_i      (tick_i),
      .wr_en_i     (wr_en_i),
      .wr_addr_i   (wr_addr_i),
      .wr_data_i   (wr_data_i),
      .start_i     (start_i),
      .stop_i      (stop_i),
      .loop_en_i   (loop_en_i),
      .length_i    (length_i),
      .tempo_i     (tempo_i),
      .period_o    (period_o),
      .dynamics_R_o(dynamics_R_o),
      .pluck_o     (pluck_o),
      .busy_o      (busy_o),
      .step_o      (step_o),
      .done_o      (done_o)
   );

   function automatic logic [31:0] pk(input logic [DW-1:0] p, input logic [DW-1:0] d,
                                      input logic pl, input logic bu, input logic dn,
                                      input logic [SW-1:0] st);
      return {9'b0, p, d, pl, bu, dn, st};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model: each step is a budget of duration*(tempo+1) ticks;
   // the pluck lasts PL ticks or until that budget runs out.
   logic [DW-1:0] m_mem [NS][3];
   logic [DW-1:0] m_period, m_dyn;
   bit m_loading, m_playing, m_pluck, m_done;
   int m_step, m_len, m_tempo, m_left, m_pticks;

   always @(posedge clk) begin
      int dur;
      if (rst_i) begin
         m_loading = 0; m_playing = 0; m_pluck = 0; m_done = 0;
         m_step = 0; m_len = 0; m_tempo = 0; m_left = 0; m_pticks = 0;
         m_period = '0; m_dyn = '0;
      end else begin
         m_done = 0;
         if (stop_i) begin
            m_loading = 0; m_playing = 0; m_pluck = 0;
         end else if (m_loading) begin
            m_period = m_mem[m_step][0];
            m_dyn    = m_mem[m_step][1];
            dur      = (m_mem[m_step][2] == 0) ? (1 << DW) : int'(m_mem[m_step][2]);
            m_left   = dur * (m_tempo + 1);
            m_pticks = 0; m_pluck = 1; m_loading = 0; m_playing = 1;
         end else if (m_playing) begin
            if (tick_i) begin
               m_left--; m_pticks++;
               if (m_pticks >= PL) m_pluck = 0;
               if (m_left == 0) begin
                  m_pluck = 0; m_playing = 0;
                  if (m_step + 1 < m_len) begin m_step++; m_loading = 1; end
                  else if (loop_en_i) begin m_step = 0; m_loading = 1; end
                  else m_done = 1;
               end
            end
         end else if (start_i && length_i != 0) begin
            m_loading = 1; m_step = 0;
            m_len   = (int'(length_i) > NS) ? NS : int'(length_i);
            m_tempo = int'(tempo_i);
         end
      end
      if (wr_en_i && wr_addr_i[1:0] != 2'd3) m_mem[wr_addr_i[SW+1:2]][wr_addr_i[1:0]] = wr_data_i;
   end

   always @(negedge clk) begin
      if (chk_en)
         check("model", pk(period_o, dynamics_R_o, pluck_o, busy_o, done_o, step_o),
               pk(m_period, m_dyn, m_pluck, m_loading || m_playing, m_done, SW'(m_step)));
   end

   task automatic wr(input int step, input int fld, input int val);
      wr_en_i = 1'b1; wr_addr_i = {SW'(step), 2'(fld)}; wr_data_i = DW'(val);
      @(negedge clk);
      wr_en_i = 1'b0;
   endtask

   task automatic prog(input int step, input int p, input int r, input int d);
      wr(step, 0, p); wr(step, 1, r); wr(step, 2, d);
   endtask

   task automatic pulse_start();
      start_i = 1'b1; @(negedge clk); start_i = 1'b0;
   endtask

   typedef struct {
      bit start; bit tick; int period; int dyn; bit pluck; bit busy; bit done; int step;
   } vec_t;

   initial begin
      vec_t tbl[9];
      int   rises_q[$];
      int   exp_seq[6] = '{0, 1, 2, 0, 1, 2};
      int   ticks, fall_ticks, done_cyc, ndone, rises, fld;
      bit   prev;

      tbl[0] = '{1, 1,  0,   0, 0, 1, 0, 0};
      tbl[1] = '{0, 1, 40, 200, 1, 1, 0, 0};
      tbl[2] = '{0, 1, 40, 200, 1, 1, 0, 0};
      tbl[3] = '{0, 1, 40, 200, 1, 1, 0, 0};
      tbl[4] = '{0, 1, 40, 200, 0, 1, 0, 1};
      tbl[5] = '{0, 1, 20, 100, 1, 1, 0, 1};
      tbl[6] = '{0, 1, 20, 100, 1, 1, 0, 1};
      tbl[7] = '{0, 1, 20, 100, 0, 0, 1, 1};
      tbl[8] = '{0, 1, 20, 100, 0, 0, 0, 1};

      rst_i = 1'b1; tick_i = 0; wr_en_i = 0; start_i = 0; stop_i = 0; loop_en_i = 0;
      wr_addr_i = '0; wr_data_i = '0; length_i = '0; tempo_i = '0;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      check("reset", pk(period_o, dynamics_R_o, pluck_o, busy_o, done_o, step_o), '0);
      chk_en = 1'b1;

      for (int s = 0; s < NS; s++) prog(s, s + 1, 128, 1);

      // Programming and single pass, table driven.
      prog(0, 40, 200, 3);
      prog(1, 20, 100, 2);
      length_i = 2; tempo_i = 0; tick_i = 1; loop_en_i = 0;
      for (int i = 0; i < 9; i++) begin
         start_i = tbl[i].start; tick_i = tbl[i].tick;
         @(negedge clk);
         check($sformatf("vec%0d", i), pk(period_o, dynamics_R_o, pluck_o, busy_o, done_o, step_o),
               pk(DW'(tbl[i].period), DW'(tbl[i].dyn), tbl[i].pluck, tbl[i].busy, tbl[i].done,
                  SW'(tbl[i].step)));
      end

      // Tempo 2, tick every 16th cycle, duration 2.
      tick_i = 0; prog(0, 55, 77, 2);
      length_i = 1; tempo_i = 2;
      pulse_start();
      @(negedge clk);
      check("t2_pluck_rise", 32'(pluck_o), 1);
      ticks = 0; fall_ticks = -1; done_cyc = -1;
      for (int n = 1; n <= 200 && done_cyc < 0; n++) begin
         tick_i = (n % 16 == 0);
         if (tick_i) ticks++;
         @(negedge clk);
         if (!pluck_o && fall_ticks < 0) fall_ticks = ticks;
         if (done_o) done_cyc = n;
      end
      tick_i = 0;
      check("t2_pluck_ticks", 32'(fall_ticks), 4);
      check("t2_step_ticks", 32'(ticks), 6);
      check("t2_step_cycles", 32'(done_cyc), 96);

      // Looping over 3 steps, loop cleared during the second step 1.
      prog(0, 10, 1, 1); prog(1, 11, 1, 1); prog(2, 12, 1, 1);
      tempo_i = 0; length_i = 3; loop_en_i = 1; tick_i = 1;
      pulse_start();
      ndone = 0; prev = pluck_o;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (pluck_o && !prev) begin
            rises_q.push_back(int'(step_o));
            if (rises_q.size() == 5) loop_en_i = 0;
         end
         if (done_o) ndone++;
         prev = pluck_o;
      end
      check("loop_plucks", 32'(rises_q.size()), 6);
      for (int i = 0; i < 6 && i < rises_q.size(); i++)
         check($sformatf("loop_step%0d", i), 32'(rises_q[i]), 32'(exp_seq[i]));
      check("loop_done_count", 32'(ndone), 1);

      // Stop in the middle of PLAY.
      prog(0, 70, 30, 10); length_i = 1;
      pulse_start();
      @(negedge clk); @(negedge clk);
      stop_i = 1; @(negedge clk); stop_i = 0;
      check("stop_mid", pk(period_o, dynamics_R_o, pluck_o, busy_o, done_o, step_o),
            pk(70, 30, 0, 0, 0, 0));
      @(negedge clk);
      check("stop_mid_after", pk(period_o, dynamics_R_o, pluck_o, busy_o, done_o, step_o),
            pk(70, 30, 0, 0, 0, 0));

      // Stop together with the step-end tick.
      prog(0, 71, 31, 3);
      pulse_start();
      @(negedge clk); @(negedge clk); @(negedge clk);
      stop_i = 1; @(negedge clk); stop_i = 0;
      check("stop_end", pk(period_o, dynamics_R_o, pluck_o, busy_o, done_o, step_o),
            pk(71, 31, 0, 0, 0, 0));
      @(negedge clk);
      check("stop_end_after", pk(period_o, dynamics_R_o, pluck_o, busy_o, done_o, step_o),
            pk(71, 31, 0, 0, 0, 0));

      // Duration 0 means 256 units.
      prog(0, 5, 6, 0);
      pulse_start();
      @(negedge clk);
      done_cyc = -1;
      for (int n = 1; n <= 400 && done_cyc < 0; n++) begin
         @(negedge clk);
         if (done_o) done_cyc = n;
      end
      check("dur0_ticks", 32'(done_cyc), 256);

      // Start with length 0 is ignored.
      length_i = 0; start_i = 1;
      repeat (3) @(negedge clk);
      start_i = 0;
      check("len0_idle", 32'(busy_o), 0);

      // Start held while busy does not restart the step.
      prog(0, 8, 9, 5); length_i = 1;
      start_i = 1; @(negedge clk); @(negedge clk);
      done_cyc = -1; rises = 0; prev = pluck_o;
      for (int n = 1; n <= 20 && done_cyc < 0; n++) begin
         start_i = (n <= 3);
         @(negedge clk);
         if (pluck_o && !prev) rises++;
         if (done_o) done_cyc = n;
         prev = pluck_o;
      end
      start_i = 0;
      check("busy_start_len", 32'(done_cyc), 5);
      check("busy_start_plucks", 32'(rises), 0);

      // Write collision with step 1 LOAD.
      prog(0, 10, 1, 1); prog(1, 11, 2, 1); length_i = 2;
      pulse_start();
      @(negedge clk); @(negedge clk);
      wr_en_i = 1; wr_addr_i = {SW'(1), 2'd0}; wr_data_i = 8'd99;
      @(negedge clk);
      wr_en_i = 0;
      check("coll_old", pk(period_o, dynamics_R_o, pluck_o, busy_o, done_o, step_o),
            pk(11, 2, 1, 1, 0, 1));
      @(negedge clk);
      pulse_start();
      @(negedge clk); @(negedge clk); @(negedge clk);
      check("coll_new", pk(period_o, dynamics_R_o, pluck_o, busy_o, done_o, step_o),
            pk(99, 2, 1, 1, 0, 1));
      @(negedge clk);

      // Randomized run, checked cycle by cycle against the model.
      for (int c = 0; c < 4000; c++) begin
         tick_i  = 1'($urandom_range(0, 1));
         start_i = ($urandom_range(0, 3) == 0);
         stop_i  = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 63) == 0) loop_en_i = ~loop_en_i;
         length_i = (SW + 1)'($urandom_range(0, 4));
         tempo_i  = TW'($urandom_range(0, 2));
         wr_en_i  = ($urandom_range(0, 7) == 0);
         fld      = int'($urandom_range(0, 3));
         wr_addr_i = {SW'($urandom_range(0, 3)), 2'(fld)};
         wr_data_i = (fld == 2) ? DW'($urandom_range(1, 4)) : DW'($urandom);
         rst_i    = ($urandom_range(0, 999) == 0);
         @(negedge clk);
      end
      rst_i = 0; wr_en_i = 0; start_i = 0; stop_i = 0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
